// File: rtl/dsi_regs_pkg.sv
// Register map, status bit positions and FSM encodings for the DSI command slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsi_regs;

    localparam logic [6:0] REG_STATUS       = 7'h24;
    localparam logic [6:0] REG_STATUS_ALIAS = 7'h00;
    localparam logic [6:0] REG_CMDCNT       = 7'h28;

    localparam int STATUS_BUSY_FIFO = 11;
    localparam int STATUS_BUSY_TX   = 10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Writes to the local control/status addresses never become DSI commands.
    function automatic logic is_ctrl_addr(input logic [6:0] addr);
        return (addr == REG_STATUS) || (addr == REG_STATUS_ALIAS) || (addr == REG_CMDCNT);
    endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// Single-clock command FIFO exposing the head entry and the entry behind it.
// Latency: push visible at the head one cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; caller reserves space.
module cmd_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 39,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             core_clk_i,
    input  logic             arst_n_i,
    input  logic             push_i,
    input  logic [DW-1:0]    push_dat_i,
    input  logic             pop_i,
    output logic [DW-1:0]    head_dat_o,
    output logic [DW-1:0]    next_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_dat_o = mem_q[rd_ptr_q];
    assign next_dat_o = mem_q[rd_ptr_q + AW'(1)];

    always_ff @(posedge core_clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge core_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dsi_cmd_axil_slave.sv
// AXI4-Lite slave queueing register writes as DSI commands; exposes status/count reads.
// Latency: w handshake to o_cmd_valid 2 cycles when idle; read data 1 cycle after ar handshake.
// Backpressure: awready drops while the FIFO is full; output register holds until i_cmd_ready.
module dsi_cmd_axil_slave
    import dsi_regs::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int ADDR_W     = 7,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_axi_clk,
    input  logic              i_restn,
    input  logic [ADDR_W-1:0] i_axi_awaddr,
    input  logic              i_axi_awvalid,
    output logic              o_axi_awready,
    input  logic [31:0]       i_axi_wdata,
    input  logic              i_axi_wvalid,
    output logic              o_axi_wready,
    output logic              o_axi_bvalid,
    input  logic              i_axi_bready,
    input  logic [ADDR_W-1:0] i_axi_araddr,
    input  logic              i_axi_arvalid,
    output logic              o_axi_arready,
    output logic [31:0]       o_axi_rdata,
    output logic              o_axi_rvalid,
    input  logic              i_axi_rready,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic [ADDR_W-1:0] o_cmd_addr,
    output logic [31:0]       o_cmd_data,
    output logic [LVL_W-1:0]  o_fifo_level
);

    localparam int CMD_W = ADDR_W + 32;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              live_q;
    logic              cmd_vld_q, cmd_vld_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              push_vld, cmd_hs;
    logic              fifo_full, fifo_empty;
    logic [CMD_W-1:0]  head_dat, next_dat;
    logic [LVL_W-1:0]  level;
    logic [31:0]       status_dat;

    // The output register mirrors the FIFO head, so the level counts the command on o_cmd_*.
    cmd_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (CMD_W)
    ) u_fifo (
        .core_clk_i (i_axi_clk),
        .arst_n_i   (i_restn),
        .push_i     (push_vld),
        .push_dat_i ({awaddr_q, i_axi_wdata}),
        .pop_i      (cmd_hs),
        .head_dat_o (head_dat),
        .next_dat_o (next_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level)
    );

    assign cmd_hs       = cmd_vld_q && i_cmd_ready;
    assign o_cmd_valid  = cmd_vld_q;
    assign o_cmd_addr   = cmd_q[CMD_W-1:32];
    assign o_cmd_data   = cmd_q[31:0];
    assign o_fifo_level = level;
    assign o_axi_rdata  = rdata_q;

    always_comb begin
        status_dat                   = '0;
        status_dat[LVL_W-1:0]        = level;
        status_dat[STATUS_BUSY_FIFO] = !fifo_empty;
        status_dat[STATUS_BUSY_TX]   = cmd_vld_q;
    end

    always_comb begin
        w_state_d     = w_state_q;
        awaddr_d      = awaddr_q;
        o_axi_awready = 1'b0;
        o_axi_wready  = 1'b0;
        o_axi_bvalid  = 1'b0;
        push_vld      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // Gating on full here reserves the slot the W beat will use.
                o_axi_awready = live_q && !fifo_full;
                if (i_axi_awvalid && o_axi_awready) begin
                    awaddr_d  = i_axi_awaddr;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                o_axi_wready = 1'b1;
                if (i_axi_wvalid) begin
                    push_vld  = !is_ctrl_addr(awaddr_q);
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                o_axi_bvalid = 1'b1;
                if (i_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        rdata_d       = rdata_q;
        o_axi_arready = 1'b0;
        o_axi_rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                o_axi_arready = live_q;
                if (i_axi_arvalid && live_q) begin
                    if (i_axi_araddr == REG_STATUS || i_axi_araddr == REG_STATUS_ALIAS) begin
                        rdata_d = status_dat;
                    end else if (i_axi_araddr == REG_CMDCNT) begin
                        rdata_d = {16'h0, cnt_q};
                    end else begin
                        rdata_d = '0;
                    end
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                o_axi_rvalid = 1'b1;
                if (i_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        cmd_vld_d = cmd_vld_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        if (!cmd_vld_q && !fifo_empty) begin
            cmd_vld_d = 1'b1;
            cmd_d     = head_dat;
        end else if (cmd_hs) begin
            cnt_d = cnt_q + 16'd1;
            if (level > LVL_W'(1)) begin
                cmd_d = next_dat;
            end else begin
                cmd_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_restn) begin
        if (!i_restn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            rdata_q   <= '0;
            live_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            rdata_q   <= rdata_d;
            live_q    <= 1'b1;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dsi_cmd_axil_slave.sv
// Scoreboard bench for dsi_cmd_axil_slave: queued writes must emerge in order on the command port.
module tb_dsi_cmd_axil_slave;

    logic        i_axi_clk = 1'b0;
    logic        i_restn;
    logic [6:0]  i_axi_awaddr;
    logic        i_axi_awvalid;
    logic        o_axi_awready;
    logic [31:0] i_axi_wdata;
    logic        i_axi_wvalid;
    logic        o_axi_wready;
    logic        o_axi_bvalid;
    logic        i_axi_bready;
    logic [6:0]  i_axi_araddr;
    logic        i_axi_arvalid;
    logic        o_axi_arready;
    logic [31:0] o_axi_rdata;
    logic        o_axi_rvalid;
    logic        i_axi_rready;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic [6:0]  o_cmd_addr;
    logic [31:0] o_cmd_data;
    logic [4:0]  o_fifo_level;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          w_hs_cyc     = 0;
    int          last_cmd_cyc = -1;
    logic [38:0] sb_q[$];
    logic [38:0] mon_exp;

    dsi_cmd_axil_slave dut (
        .i_axi_clk     (i_axi_clk),
        .i_restn       (i_restn),
        .i_axi_awaddr  (i_axi_awaddr),
        .i_axi_awvalid (i_axi_awvalid),
        .o_axi_awready (o_axi_awready),
        .i_axi_wdata   (i_axi_wdata),
        .i_axi_wvalid  (i_axi_wvalid),
        .o_axi_wready  (o_axi_wready),
        .o_axi_bvalid  (o_axi_bvalid),
        .i_axi_bready  (i_axi_bready),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_cmd_addr    (o_cmd_addr),
        .o_cmd_data    (o_cmd_data),
        .o_fifo_level  (o_fifo_level)
    );

    always #5 i_axi_clk = ~i_axi_clk;
    always @(posedge i_axi_clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change only at posedge+1, so a negedge view predicts the next edge's handshake.
    always @(negedge i_axi_clk) begin
        if (i_restn && o_cmd_valid && i_cmd_ready) begin
            chk("cmd_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                chk("cmd", {o_cmd_addr, o_cmd_data}, mon_exp);
            end
            last_cmd_cyc = cyc;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_awready"}, o_axi_awready, 0);
        chk({tag, "_wready"},  o_axi_wready,  0);
        chk({tag, "_bvalid"},  o_axi_bvalid,  0);
        chk({tag, "_arready"}, o_axi_arready, 0);
        chk({tag, "_rvalid"},  o_axi_rvalid,  0);
        chk({tag, "_rdata"},   o_axi_rdata,   0);
        chk({tag, "_cvalid"},  o_cmd_valid,   0);
        chk({tag, "_caddr"},   o_cmd_addr,    0);
        chk({tag, "_cdata"},   o_cmd_data,    0);
        chk({tag, "_level"},   o_fifo_level,  0);
    endtask

    task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input int w_lead);
        if (!(a inside {7'h24, 7'h28, 7'h00})) sb_q.push_back({a, d});
        @(posedge i_axi_clk); #1;
        i_axi_awaddr = a;
        i_axi_wdata  = d;
        if (w_lead > 0) begin
            i_axi_wvalid = 1'b1;
            repeat (w_lead) begin
                @(negedge i_axi_clk);
                chk("w_before_aw_wready", o_axi_wready, 0);
            end
            @(posedge i_axi_clk); #1;
        end
        i_axi_awvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge i_axi_clk);
            if (o_axi_awready) break;
        end
        chk("aw_handshake", o_axi_awready, 1);
        @(posedge i_axi_clk); #1;
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_axi_clk);
            if (o_axi_wready) break;
        end
        chk("w_handshake", o_axi_wready, 1);
        w_hs_cyc = cyc;
        @(posedge i_axi_clk); #1;
        i_axi_wvalid = 1'b0;
        i_axi_bready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_axi_clk);
            if (o_axi_bvalid) break;
        end
        chk("bvalid", o_axi_bvalid, 1);
        @(posedge i_axi_clk); #1;
        i_axi_bready = 1'b0;
        @(negedge i_axi_clk);
        chk("bvalid_single", o_axi_bvalid, 0);
    endtask

    task automatic axi_rd(input logic [6:0] a, input logic [31:0] exp, input int hold, input string tag);
        @(posedge i_axi_clk); #1;
        i_axi_araddr  = a;
        i_axi_arvalid = 1'b1;
        i_axi_rready  = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_axi_clk);
            if (o_axi_arready) break;
        end
        chk({tag, "_ar"}, o_axi_arready, 1);
        @(posedge i_axi_clk); #1;
        i_axi_arvalid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_axi_rvalid) break;
            @(negedge i_axi_clk);
        end
        repeat (hold) begin
            chk({tag, "_hold_rvalid"}, o_axi_rvalid, 1);
            chk({tag, "_hold_rdata"},  o_axi_rdata,  exp);
            @(negedge i_axi_clk);
        end
        chk({tag, "_rvalid"}, o_axi_rvalid, 1);
        chk(tag, o_axi_rdata, exp);
        @(posedge i_axi_clk); #1;
        i_axi_rready = 1'b1;
        @(posedge i_axi_clk); #1;
        i_axi_rready = 1'b0;
        @(negedge i_axi_clk);
        chk({tag, "_rvalid_drop"}, o_axi_rvalid, 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 300; n++) begin
            @(negedge i_axi_clk);
            if (sb_q.size() == 0 && !o_cmd_valid) break;
        end
        chk(tag, sb_q.size(), 0);
        chk({tag, "_level"}, o_fifo_level, 0);
    endtask

    initial begin
        i_restn       = 1'b0;
        i_axi_awaddr  = '0;
        i_axi_awvalid = 1'b0;
        i_axi_wdata   = '0;
        i_axi_wvalid  = 1'b0;
        i_axi_bready  = 1'b0;
        i_axi_araddr  = '0;
        i_axi_arvalid = 1'b0;
        i_axi_rready  = 1'b0;
        i_cmd_ready   = 1'b0;
        #2;
        chk_outputs_zero("rst");
        repeat (3) @(posedge i_axi_clk);
        #1 i_restn = 1'b1;

        // 1: single write, 2-cycle dispatch latency, counter
        i_cmd_ready = 1'b1;
        axi_wr(7'h10, 32'hDEADBEEF, 0);
        repeat (4) @(negedge i_axi_clk);
        chk("dispatch_latency", last_cmd_cyc, w_hs_cyc + 2);
        axi_rd(7'h28, 32'd1, 0, "cnt_after_1");

        // 2: fill to full, 17th AW stalls, status, drain in order
        i_cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) axi_wr(7'(7'h40 + i), 32'hA5000000 | i, 0);
        fork
            axi_wr(7'h00, 32'h0, 0);
            begin
                repeat (5) begin
                    @(negedge i_axi_clk);
                    chk("full_awready", o_axi_awready, 0);
                end
                axi_rd(7'h24, 32'h0000_0C10, 0, "status_full");
                @(posedge i_axi_clk); #1;
                i_cmd_ready = 1'b1;
                @(negedge i_axi_clk);
                chk("full_pop_awready", o_axi_awready, 0);
            end
        join
        wait_drain("drain_full");
        axi_rd(7'h24, 32'h0, 0, "status_empty");
        axi_rd(7'h28, 32'd17, 0, "cnt_after_17");

        // 3: write to STATUS is discarded
        axi_wr(7'h24, 32'hFFFFFFFF, 0);
        repeat (4) @(negedge i_axi_clk);
        chk("discard_level", o_fifo_level, 0);
        chk("discard_cvalid", o_cmd_valid, 0);
        axi_rd(7'h28, 32'd17, 0, "cnt_after_discard");

        // 4: W presented before AW, alias read of STATUS meanwhile
        i_cmd_ready = 1'b0;
        axi_wr(7'h18, 32'h11112222, 0);
        repeat (3) @(negedge i_axi_clk);
        fork
            axi_wr(7'h14, 32'h33334444, 5);
            begin
                @(negedge i_axi_clk);
                axi_rd(7'h00, 32'h0000_0C01, 0, "alias_status");
            end
        join
        @(negedge i_axi_clk);
        chk("level_two", o_fifo_level, 2);
        i_cmd_ready = 1'b1;
        wait_drain("drain_w_first");

        // 5: stalled read data stays stable while a write completes
        fork
            axi_rd(7'h28, 32'd19, 10, "cnt_hold");
            axi_wr(7'h1C, 32'h55667788, 0);
        join
        wait_drain("drain_concurrent");
        axi_rd(7'h28, 32'd20, 0, "cnt_after_20");
        axi_rd(7'h30, 32'h0, 0, "unmapped");

        // 6: reset with queued commands
        i_cmd_ready = 1'b0;
        axi_wr(7'h20, 32'h0000_0020, 0);
        axi_wr(7'h21, 32'h0000_0021, 0);
        axi_wr(7'h22, 32'h0000_0022, 0);
        repeat (3) @(negedge i_axi_clk);
        chk("pre_rst_cvalid", o_cmd_valid, 1);
        chk("pre_rst_level", o_fifo_level, 3);
        @(posedge i_axi_clk); #1;
        i_restn = 1'b0;
        sb_q.delete();
        #1;
        chk_outputs_zero("midrst");
        repeat (3) @(posedge i_axi_clk);
        #1 i_restn = 1'b1;
        i_cmd_ready = 1'b1;
        repeat (5) @(negedge i_axi_clk);
        chk("post_rst_cvalid", o_cmd_valid, 0);
        axi_rd(7'h24, 32'h0, 0, "post_rst_status");
        axi_rd(7'h28, 32'h0, 0, "post_rst_cnt");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
